ula_port_ctrl: RTL and testbench

ULA_PORT_CTRL -- requirements
Module: ula_port_ctrl

---
 rtl/ula_port_ctrl.sv | 144 ++++++++++++++
 tb/tb_ula_port_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ula_port_ctrl.sv
// ULA port controller: port 0xFE write latches, keyboard/EAR read path,
// frame counter with interrupt, turbo frame length and beeper activity divider.
// Ports: clk_cpu/reset/ce clocking; turbo; A/D/io_we CPU IO; key_matrix, ear_in
// inputs; ula_data read bus; border/ear_out/mic_out latches; vs_nintr,
// frame_start frame timing; beeper divided audio activity.
module ula_port_ctrl #(
  parameter int NUM_ROWS     = 8,
  parameter int FRAME_TSTATES = 69888,
  parameter int INT_WIDTH    = 32,
  parameter int BEEP_DIV_W   = 7,
  parameter bit FULL_DECODE  = 1'b0
) (
  input  logic                    clk_cpu,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    turbo,
  input  logic [15:0]             A,
  input  logic [7:0]              D,
  input  logic                    io_we,
  input  logic [NUM_ROWS*5-1:0]   key_matrix,
  input  logic                    ear_in,
  output logic [7:0]              ula_data,
  output logic [2:0]              border,
  output logic                    ear_out,
  output logic                    mic_out,
  output logic                    vs_nintr,
  output logic                    frame_start,
  output logic                    beeper
);

  localparam int CW = $clog2(2*FRAME_TSTATES);
  localparam logic [CW-1:0] LAST_N = CW'(FRAME_TSTATES-1);
  localparam logic [CW-1:0] LAST_T = CW'(2*FRAME_TSTATES-1);
  localparam logic [CW-1:0] INT_W  = CW'(INT_WIDTH);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [2:0]            border_q, border_d;
  logic                  ear_q, ear_d;
  logic                  mic_q, mic_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  turbo_l_q, turbo_l_d;
  logic                  vs_q, vs_d;
  logic                  fs_q, fs_d;
  logic                  act_q, act_d;
  logic [BEEP_DIV_W-1:0] bcnt_q, bcnt_d;
  logic                  beep_q, beep_d;

  logic       port_hit;
  logic [4:0] keys;
  logic       wrap;
  logic       act;
  logic       rise;

  assign port_hit = FULL_DECODE ? (A[7:0] == 8'hFE) : ~A[0];

  // A row participates when its address line is pulled low
  always_comb begin
    keys = 5'h1F;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!A[8+r]) keys = keys & key_matrix[5*r +: 5];
    end
  end

  assign ula_data = port_hit ? {1'b1, sync2_q, 1'b1, keys} : 8'hFF;

  assign wrap = (cnt_q == (turbo_l_q ? LAST_T : LAST_N));
  assign act  = ear_q ^ mic_q ^ sync2_q;
  assign rise = act & ~act_q;

  always_comb begin
    sync1_d   = ear_in;
    sync2_d   = sync1_q;
    border_d  = border_q;
    ear_d     = ear_q;
    mic_d     = mic_q;
    cnt_d     = cnt_q;
    turbo_l_d = turbo_l_q;
    vs_d      = vs_q;
    fs_d      = 1'b0;
    act_d     = act_q;
    bcnt_d    = bcnt_q;
    beep_d    = beep_q;
    if (ce) begin
      if (io_we && port_hit) begin
        border_d = D[2:0];
        mic_d    = D[3];
        ear_d    = D[4];
      end
      if (wrap) begin
        cnt_d     = '0;
        turbo_l_d = turbo;
        fs_d      = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      vs_d  = ~(cnt_q < INT_W);
      act_d = act;
      if (rise) begin
        bcnt_d = bcnt_q - BEEP_DIV_W'(1);
        // divider expiry: one toggle per full wrap of bcnt
        if (bcnt_q == '0) beep_d = ~beep_q;
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      border_q  <= 3'd0;
      ear_q     <= 1'b0;
      mic_q     <= 1'b0;
      cnt_q     <= '0;
      turbo_l_q <= turbo;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
      act_q     <= 1'b0;
      bcnt_q    <= '0;
      beep_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      border_q  <= border_d;
      ear_q     <= ear_d;
      mic_q     <= mic_d;
      cnt_q     <= cnt_d;
      turbo_l_q <= turbo_l_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      act_q     <= act_d;
      bcnt_q    <= bcnt_d;
      beep_q    <= beep_d;
    end
  end

  assign border      = border_q;
  assign ear_out     = ear_q;
  assign mic_out     = mic_q;
  assign vs_nintr    = vs_q;
  assign frame_start = fs_q;
  assign beeper      = beep_q;

endmodule

// File: tb/tb_ula_port_ctrl.sv
// Randomized bench for ula_port_ctrl with a frame/port/beeper reference model.
// Two instances: partial decode (8 rows) and full decode (4 rows).
module tb_ula_port_ctrl;

  localparam int FT   = 150;
  localparam int IW   = 12;
  localparam int BW   = 2;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        reset, ce, turbo, io_we, ear_in;
  logic [15:0] A;
  logic [7:0]  D;
  logic [39:0] km;

  logic [7:0]  ula_data, ula_data2;
  logic [2:0]  border, border2;
  logic        ear_out, mic_out, vs_nintr, frame_start, beeper;
  logic        ear2, mic2, vs2, fs2, beep2;

  always #5 clk = ~clk;

  ula_port_ctrl #(
    .NUM_ROWS(8), .FRAME_TSTATES(FT), .INT_WIDTH(IW),
    .BEEP_DIV_W(BW), .FULL_DECODE(1'b0)
  ) dut (
    .clk_cpu(clk), .reset(reset), .ce(ce), .turbo(turbo),
    .A(A), .D(D), .io_we(io_we), .key_matrix(km), .ear_in(ear_in),
    .ula_data(ula_data), .border(border), .ear_out(ear_out),
    .mic_out(mic_out), .vs_nintr(vs_nintr), .frame_start(frame_start),
    .beeper(beeper)
  );

  ula_port_ctrl #(
    .NUM_ROWS(4), .FRAME_TSTATES(FT), .INT_WIDTH(IW),
    .BEEP_DIV_W(BW), .FULL_DECODE(1'b1)
  ) dut_fd (
    .clk_cpu(clk), .reset(reset), .ce(ce), .turbo(turbo),
    .A(A), .D(D), .io_we(io_we), .key_matrix(km[19:0]), .ear_in(ear_in),
    .ula_data(ula_data2), .border(border2), .ear_out(ear2),
    .mic_out(mic2), .vs_nintr(vs2), .frame_start(fs2),
    .beeper(beep2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference state
  int   pos, flen, nrise;
  bit   m_vs, m_fs, m_actq, s1, s2;
  bit [2:0] m_bd, m_bd2;
  bit   m_ear, m_mic, m_ear2, m_mic2;

  function automatic bit [4:0] keys_of(input bit [15:0] a,
                                       input bit [39:0] k, input int rows);
    bit [4:0] r = 5'h1F;
    for (int i = 0; i < rows; i++)
      if (!a[8+i]) r &= k[5*i +: 5];
    return r;
  endfunction

  function automatic bit [7:0] rd_exp(input bit hit, input bit [4:0] k);
    return hit ? {1'b1, s2, 1'b1, k} : 8'hFF;
  endfunction

  task automatic model_step();
    bit act, hit1, hit2, last;
    act  = m_ear ^ m_mic ^ s2;
    hit1 = !A[0];
    hit2 = (A[7:0] == 8'hFE);
    if (reset) begin
      pos = 0; flen = turbo ? 2*FT : FT; nrise = 0;
      m_vs = 1; m_fs = 0; m_actq = 0; s1 = 0; s2 = 0;
      m_bd = 0; m_ear = 0; m_mic = 0;
      m_bd2 = 0; m_ear2 = 0; m_mic2 = 0;
    end else begin
      s2 = s1; s1 = ear_in;
      m_fs = 0;
      if (ce) begin
        last = (pos == flen - 1);
        m_vs = (pos >= IW);
        m_fs = last;
        if (last) begin
          pos = 0; flen = turbo ? 2*FT : FT;
        end else pos++;
        if (act && !m_actq) nrise++;
        m_actq = act;
        if (io_we && hit1) begin
          m_bd = D[2:0]; m_mic = D[3]; m_ear = D[4];
        end
        if (io_we && hit2) begin
          m_bd2 = D[2:0]; m_mic2 = D[3]; m_ear2 = D[4];
        end
      end
    end
  endtask

  task automatic check_regs();
    int div = 1 << BW;
    chk("border", 32'(border), 32'(m_bd));
    chk("ear_out", 32'(ear_out), 32'(m_ear));
    chk("mic_out", 32'(mic_out), 32'(m_mic));
    chk("vs_nintr", 32'(vs_nintr), 32'(m_vs));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    // toggles on rising edges 1, 1+div, 1+2*div, ...
    chk("beeper", 32'(beeper), 32'(((nrise + div - 1) / div) % 2));
    chk("fd_border", 32'(border2), 32'(m_bd2));
    chk("fd_ear", 32'(ear2), 32'(m_ear2));
    chk("fd_mic", 32'(mic2), 32'(m_mic2));
  endtask

  task automatic rand_inputs();
    int sel;
    reset  = ($urandom_range(0, 499) == 0);
    ce     = ($urandom_range(0, 7) != 0);
    io_we  = ($urandom_range(0, 3) == 0);
    ear_in = ($urandom_range(0, 5) == 0) ? ~ear_in : ear_in;
    if ($urandom_range(0, 249) == 0) turbo = ~turbo;
    sel = $urandom_range(0, 3);
    A[15:8] = 8'($urandom);
    case (sel)
      0: A[7:0] = 8'hFE;
      1: A[7:0] = 8'hFC;
      2: A[7:0] = 8'hFD;
      default: A[7:0] = 8'($urandom);
    endcase
    D  = 8'($urandom);
    km = {8'($urandom), 32'($urandom)};
  endtask

  initial begin
    reset = 1; ce = 0; turbo = 0; io_we = 0; ear_in = 0;
    A = 16'hFFFF; D = 8'h00; km = '1;
    @(posedge clk); #1;
    model_step();
    @(posedge clk); #1;
    model_step();
    check_regs();
    reset = 0; ce = 1;

    // full first frame with ce held high, turbo off
    for (int c = 1; c <= FT + 1; c++) begin
      @(posedge clk); #1;
      model_step();
      if (c == 1 || c == IW || c == IW + 1 || c == FT || c == FT + 1) begin
        chk("frm_vs", 32'(vs_nintr), 32'((c > IW && c <= FT) ? 1 : 0));
        chk("frm_fs", 32'(frame_start), 32'(c == FT ? 1 : 0));
      end
    end

    for (int c = 0; c < NCYC; c++) begin
      rand_inputs();
      #2;
      chk("ula_data", 32'(ula_data),
          32'(rd_exp(!A[0], keys_of(A, km, 8))));
      chk("fd_ula_data", 32'(ula_data2),
          32'(rd_exp(A[7:0] == 8'hFE, keys_of(A, km, 4))));
      @(posedge clk); #1;
      model_step();
      check_regs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
